lsu_rmw_ctrl: RTL and testbench

Store sequencer for the load-store unit's word-wide data memory. Accepts one store request at a time and issues memory transactions. Word stores go out as a single write. Byte and halfword stores run a read-modify-write: read the aligned word, merge the new lanes in, write the word back. The block sits between the LSU store path and the data-memory port, and owns the sub-word lane-merge logic.

---
 rtl/lsu_rmw_ctrl_pkg.sv | 49 ++++
 rtl/lsu_rmw_ctrl_if.sv | 33 +++
 rtl/lsu_rmw_ctrl_lane_merge.sv | 34 +++
 rtl/lsu_rmw_ctrl.sv | 124 ++++++++++++
 tb/tb_lsu_rmw_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_rmw_ctrl_pkg.sv
// Shared LSU store-path types and helpers: store type encoding, sequencer state
// encoding, lane replication and the alignment/legality check.
package lsu_rmw_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BYTE = 2'd0,
        ST_HALF = 2'd1,
        ST_WORD = 2'd2
    } st_type_e;

    typedef enum logic [1:0] {
        RMW_IDLE  = 2'd0,
        RMW_READ  = 2'd1,
        RMW_WRITE = 2'd2,
        RMW_RESP  = 2'd3
    } rmw_state_e;

    // Plain-vector views of the state encoding for the state register.
    localparam logic [1:0] S_IDLE  = RMW_IDLE;
    localparam logic [1:0] S_READ  = RMW_READ;
    localparam logic [1:0] S_WRITE = RMW_WRITE;
    localparam logic [1:0] S_RESP  = RMW_RESP;

    // Spread right-justified store data across every lane it could land in.
    function automatic logic [31:0] lane_replicate(input logic [31:0] data,
                                                   input logic [1:0]  st_type);
        logic [31:0] rep;
        case (st_type)
            ST_BYTE: rep = {4{data[7:0]}};
            ST_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    // Type 3, odd halfword and non-word-aligned word stores are rejected.
    function automatic logic store_illegal(input logic [1:0] st_type,
                                           input logic [1:0] lane);
        logic bad;
        case (st_type)
            ST_BYTE: bad = 1'b0;
            ST_HALF: bad = lane[0];
            ST_WORD: bad = (lane != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_rmw_ctrl_if.sv
// Store-request and data-memory port bundle between the LSU store path, the
// store sequencer and the word-wide data memory.
interface lsu_rmw_ctrl_if;

    logic        i_st_valid;
    logic        o_st_ready;
    logic [31:0] i_st_addr;
    logic [31:0] i_st_data;
    logic [1:0]  i_st_type;
    logic        o_st_done;
    logic        o_st_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    // Sequencer side.
    modport slave (
        input  i_st_valid, i_st_addr, i_st_data, i_st_type, i_mem_ack, i_mem_rdata,
        output o_st_ready, o_st_done, o_st_err, o_mem_req, o_mem_we, o_mem_addr,
        output o_mem_wdata
    );

    // Requester and memory side.
    modport master (
        output i_st_valid, i_st_addr, i_st_data, i_st_type, i_mem_ack, i_mem_rdata,
        input  o_st_ready, o_st_done, o_st_err, o_mem_req, o_mem_we, o_mem_addr,
        input  o_mem_wdata
    );

endinterface

// File: rtl/lsu_rmw_ctrl_lane_merge.sv
// Sub-word lane merge: overlays the replicated store data onto the old memory
// word for byte and halfword stores; word stores pass straight through.
module lsu_lane_merge
    import lsu_rmw_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] rep_data,
    input  logic [1:0]  st_type,
    input  logic [1:0]  lane,
    output logic [31:0] new_word
);

    // Select each byte lane from either the old word or the new data.
    always_comb begin
        new_word = rep_data;
        case (st_type)
            ST_BYTE: begin
                new_word = old_word;
                case (lane)
                    2'd0:    new_word[7:0]   = rep_data[7:0];
                    2'd1:    new_word[15:8]  = rep_data[15:8];
                    2'd2:    new_word[23:16] = rep_data[23:16];
                    default: new_word[31:24] = rep_data[31:24];
                endcase
            end
            ST_HALF: begin
                new_word = lane[1] ? {rep_data[31:16], old_word[15:0]}
                                   : {old_word[31:16], rep_data[15:0]};
            end
            default: new_word = rep_data;
        endcase
    end

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// Store sequencer for the LSU data-memory port. Word stores issue one write;
// byte and halfword stores read the aligned word, merge, and write it back.
// All outputs come from registers or registered state.
module lsu_rmw_ctrl
    import lsu_rmw_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic          i_clk,
    input logic          i_rst,
    lsu_rmw_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    // Last no-ack cycle allowed before the transaction is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       type_q, type_d;
    logic [31:0]      old_q, old_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_bad;
    logic [31:0]      merged;

    assign accept_bad = store_illegal(bus.i_st_type, bus.i_st_addr[1:0]);

    lsu_lane_merge u_merge (
        .old_word (old_q),
        .rep_data (data_q),
        .st_type  (type_q),
        .lane     (addr_q[1:0]),
        .new_word (merged)
    );

    // Next-state: acceptance/legality routing, ack handling and ack timeout.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        old_d   = old_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_st_valid) begin
                    addr_d = bus.i_st_addr;
                    data_d = lane_replicate(bus.i_st_data, bus.i_st_type);
                    type_d = bus.i_st_type;
                    err_d  = accept_bad;
                    cnt_d  = '0;
                    if (accept_bad) begin
                        state_d = S_RESP;
                    end else if (bus.i_st_type == ST_WORD) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (bus.i_mem_ack) begin
                    old_d   = bus.i_mem_rdata;
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (bus.i_mem_ack) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any in-flight store.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= '0;
            old_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            type_q  <= type_d;
            old_q   <= old_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_st_ready  = (state_q == S_IDLE);
    assign bus.o_mem_req   = (state_q == S_READ) || (state_q == S_WRITE);
    assign bus.o_mem_we    = (state_q == S_WRITE);
    assign bus.o_mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.o_mem_wdata = merged;
    assign bus.o_st_done   = (state_q == S_RESP) && !err_q;
    assign bus.o_st_err    = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Scoreboard bench for lsu_rmw_ctrl: stimulus pushes expected memory
// transactions and responses; a monitor pops and compares on each DUT event.
module tb_lsu_rmw_ctrl;
    import lsu_rmw_ctrl_pkg::*;

    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lsu_rmw_ctrl_if bus ();

    lsu_rmw_ctrl #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit          is_resp;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        int          cyc;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          acc = 0;
    bit          mon_en = 1'b0;
    int          rd_delay = 0;
    int          wr_delay = 0;
    bit          no_ack = 1'b0;
    logic [31:0] rd_val = '0;
    int          wait_n = 0;
    int          req_run = 0;
    int          last_req_run = 0;
    int          we_cycles = 0;
    int          we0 = 0;
    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] wd);
        ev_t x;
        x.is_resp = 1'b0; x.we = we; x.addr = a; x.wdata = wd; x.err = 1'b0; x.cyc = -1;
        exp_q.push_back(x);
    endtask

    task automatic push_resp(input logic err, input int c);
        ev_t x;
        x.is_resp = 1'b1; x.we = 1'b0; x.addr = '0; x.wdata = '0; x.err = err; x.cyc = c;
        exp_q.push_back(x);
    endtask

    // Cycle counter: number of rising edges seen so far.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: ack after a per-direction number of wait cycles.
    initial begin
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.o_mem_req === 1'b1 && !no_ack) begin
                if (wait_n >= (bus.o_mem_we ? wr_delay : rd_delay)) begin
                    bus.i_mem_ack   = 1'b1;
                    bus.i_mem_rdata = rd_val;
                    wait_n          = 0;
                end else begin
                    bus.i_mem_ack   = 1'b0;
                    bus.i_mem_rdata = 32'hDEAD_0000;
                    wait_n++;
                end
            end else begin
                bus.i_mem_ack   = 1'b0;
                bus.i_mem_rdata = 32'hDEAD_0000;
                wait_n          = 0;
            end
        end
    end

    // Monitor: hold-stability, alignment, and scoreboard compare on each event.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && !rst) begin
                if (p_req && !p_ack && bus.o_mem_req === 1'b1) begin
                    check("hold_addr", bus.o_mem_addr, p_addr);
                    check("hold_we", {31'b0, bus.o_mem_we}, {31'b0, p_we});
                    check("hold_wdata", bus.o_mem_wdata, p_wd);
                end
                if (bus.o_mem_req === 1'b1) begin
                    req_run++;
                    check("addr_align", {30'b0, bus.o_mem_addr[1:0]}, 32'h0);
                    if (bus.o_mem_we === 1'b1) we_cycles++;
                end else begin
                    if (req_run > 0) last_req_run = req_run;
                    req_run = 0;
                end
                if (bus.o_mem_req === 1'b1 && bus.i_mem_ack === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_mem: got we=%0b addr=0x%08h, expected none",
                                 bus.o_mem_we, bus.o_mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("ev_kind_mem", {31'b0, e.is_resp}, 32'h0);
                        check("mem_we", {31'b0, bus.o_mem_we}, {31'b0, e.we});
                        check("mem_addr", bus.o_mem_addr, e.addr);
                        if (e.we) check("mem_wdata", bus.o_mem_wdata, e.wdata);
                    end
                end
                if (bus.o_st_done === 1'b1 || bus.o_st_err === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_resp: got done=%0b err=%0b, expected none",
                                 bus.o_st_done, bus.o_st_err);
                    end else begin
                        e = exp_q.pop_front();
                        check("ev_kind_resp", {31'b0, e.is_resp}, 32'h1);
                        check("st_err", {31'b0, bus.o_st_err}, {31'b0, e.err});
                        check("st_done", {31'b0, bus.o_st_done}, {31'b0, ~e.err});
                        if (e.cyc >= 0) check("resp_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
            p_req  = rst ? 1'b0 : (bus.o_mem_req === 1'b1);
            p_ack  = (bus.i_mem_ack === 1'b1);
            p_we   = bus.o_mem_we;
            p_addr = bus.o_mem_addr;
            p_wd   = bus.o_mem_wdata;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        int n = 0;
        @(negedge clk);
        bus.i_st_valid = 1'b1;
        bus.i_st_addr  = a;
        bus.i_st_data  = d;
        bus.i_st_type  = t;
        while (bus.o_st_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            $display("FAIL accept: got ready=%b after 50 cycles, expected 1", bus.o_st_ready);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $fatal(1, "request never accepted");
        end
        @(posedge clk);
        #1;
        acc            = cyc;
        bus.i_st_valid = 1'b0;
        bus.i_st_addr  = 32'hFFFF_FFFF;
        bus.i_st_data  = 32'hFFFF_FFFF;
        bus.i_st_type  = 2'd3;
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || bus.o_st_ready !== 1'b1) && n < bound) begin
            @(negedge clk);
            #2;
            n++;
        end
        n_checks++;
        if (exp_q.size() == 0 && bus.o_st_ready === 1'b1) begin
            n_pass++;
        end else begin
            $display("FAIL drain_%s: got %0d pending events after %0d cycles, expected 0",
                     name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        #100000;
        $display("FAIL watchdog: got no finish by 100us, expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_st_valid = 1'b0;
        bus.i_st_addr  = '0;
        bus.i_st_data  = '0;
        bus.i_st_type  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {31'b0, bus.o_st_ready}, 32'h1);
        check("rst_req", {31'b0, bus.o_mem_req}, 32'h0);
        check("rst_we", {31'b0, bus.o_mem_we}, 32'h0);
        check("rst_done", {31'b0, bus.o_st_done}, 32'h0);
        check("rst_err", {31'b0, bus.o_st_err}, 32'h0);
        check("rst_addr", bus.o_mem_addr, 32'h0);
        check("rst_wdata", bus.o_mem_wdata, 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Word store, immediate ack.
        issue(32'h100, 32'hDEADBEEF, ST_WORD);
        push_mem(1'b1, 32'h100, 32'hDEADBEEF);
        push_resp(1'b0, acc + 1);
        drain("word", 20);

        // Byte into lane 3.
        rd_val = 32'h11223344;
        issue(32'h203, 32'h0000005A, ST_BYTE);
        push_mem(1'b0, 32'h200, '0);
        push_mem(1'b1, 32'h200, 32'h5A223344);
        push_resp(1'b0, acc + 2);
        drain("byte3", 20);

        // Upper halfword, three wait cycles on each transaction.
        rd_delay = 3; wr_delay = 3; rd_val = 32'hAAAABBBB;
        issue(32'h302, 32'h0000BEEF, ST_HALF);
        push_mem(1'b0, 32'h300, '0);
        push_mem(1'b1, 32'h300, 32'hBEEFBBBB);
        push_resp(1'b0, acc + 8);
        drain("half_delay", 40);

        // Lower halfword; upper data bits must be ignored.
        rd_delay = 0; wr_delay = 0; rd_val = 32'h55667788;
        issue(32'h10, 32'h1234ABCD, ST_HALF);
        push_mem(1'b0, 32'h10, '0);
        push_mem(1'b1, 32'h10, 32'h5566ABCD);
        push_resp(1'b0, acc + 2);
        drain("half_lo", 20);

        // Byte into lane 1 and lane 2.
        rd_val = 32'h00000000;
        issue(32'h21, 32'hABCDEF9F, ST_BYTE);
        push_mem(1'b0, 32'h20, '0);
        push_mem(1'b1, 32'h20, 32'h00009F00);
        push_resp(1'b0, acc + 2);
        drain("byte1", 20);
        rd_val = 32'hFFFFFFFF;
        issue(32'h32, 32'h00000066, ST_BYTE);
        push_mem(1'b0, 32'h30, '0);
        push_mem(1'b1, 32'h30, 32'hFF66FFFF);
        push_resp(1'b0, acc + 2);
        drain("byte2", 20);

        // Word store with two-cycle write wait.
        wr_delay = 2;
        issue(32'h800, 32'hCAFEF00D, ST_WORD);
        push_mem(1'b1, 32'h800, 32'hCAFEF00D);
        push_resp(1'b0, acc + 3);
        drain("word_delay", 20);
        wr_delay = 0;

        // Rejected stores: error in the first cycle, no memory request.
        issue(32'h401, 32'h0000BEEF, ST_HALF);
        push_resp(1'b1, acc);
        drain("rej_half", 10);
        issue(32'h500, 32'h00000001, 2'd3);
        push_resp(1'b1, acc);
        drain("rej_type3", 10);
        issue(32'h402, 32'h00001234, ST_WORD);
        push_resp(1'b1, acc);
        drain("rej_word", 10);

        // No ack during READ: timeout error, no write, next store normal.
        no_ack = 1'b1;
        we0    = we_cycles;
        issue(32'h600, 32'h00000011, ST_BYTE);
        push_resp(1'b1, -1);
        drain("timeout", 40);
        check("timeout_req_run_ok",
              {31'b0, (last_req_run == TIMEOUT || last_req_run == TIMEOUT + 1)}, 32'h1);
        check("timeout_no_write", 32'(we_cycles), 32'(we0));
        no_ack = 1'b0;
        issue(32'h604, 32'h01020304, ST_WORD);
        push_mem(1'b1, 32'h604, 32'h01020304);
        push_resp(1'b0, acc + 1);
        drain("after_timeout", 20);

        // Reset while waiting on the write of an RMW store.
        rd_delay = 0; wr_delay = 6; rd_val = 32'h12345678;
        issue(32'h700, 32'h00000077, ST_BYTE);
        push_mem(1'b0, 32'h700, '0);
        n = 0;
        while (!(bus.o_mem_req === 1'b1 && bus.o_mem_we === 1'b1) && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("reached_write", {31'b0, bus.o_mem_req & bus.o_mem_we}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("rst_mid_ready", {31'b0, bus.o_st_ready}, 32'h1);
        check("rst_mid_req", {31'b0, bus.o_mem_req}, 32'h0);
        check("rst_mid_done", {31'b0, bus.o_st_done}, 32'h0);
        check("rst_mid_err", {31'b0, bus.o_st_err}, 32'h0);
        check("rst_mid_read_seen", 32'(exp_q.size()), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        wr_delay = 0; rd_val = 32'hFFFFFFFF;
        issue(32'h701, 32'h000000C3, ST_BYTE);
        push_mem(1'b0, 32'h700, '0);
        push_mem(1'b1, 32'h700, 32'hFFFFC3FF);
        push_resp(1'b0, acc + 2);
        drain("after_reset", 20);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
